// File: rtl/dpll_gear_ctrl_pkg.sv
// Shared types and limits for the DPLL loop-bandwidth (gear-shift) controller.
// Holds the FSM encoding, kMode range/width and the saturating event-count helper.
package dpll_gear_ctrl_pkg;

    localparam int K_W      = 4;
    localparam int KMODE_LO = 1;
    localparam int KMODE_HI = 15;
    localparam int EV_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

    // Event counter sticks at all-ones instead of wrapping.
    function automatic logic [EV_W-1:0] ev_sat_inc(input logic [EV_W-1:0] ev,
                                                   input logic            inc);
        logic [EV_W-1:0] res;
        res = ev;
        if (inc && (ev != {EV_W{1'b1}})) begin
            res = ev + 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dpll_gear_ctrl_if.sv
// Control/status bundle between the top-level loop control and the gear controller.
// No valid/ready handshake: inputs are level/pulse signals sampled on every rising clk edge, all outputs are registered.
interface dpll_gear_ctrl_if;
    import dpll_gear_ctrl_pkg::*;

    logic            start;
    logic            stop;
    logic            carry;
    logic            borrow;
    logic [K_W-1:0]  k_mode;
    logic            dlf_enable;
    logic            k_step;
    logic            locked;
    logic [1:0]      state_dbg;
    logic [EV_W-1:0] ev_count;

    modport master (
        output start, stop, carry, borrow,
        input  k_mode, dlf_enable, k_step, locked, state_dbg, ev_count
    );

    modport slave (
        input  start, stop, carry, borrow,
        output k_mode, dlf_enable, k_step, locked, state_dbg, ev_count
    );

endinterface

// File: rtl/dpll_gear_ctrl_event_window.sv
// Observation window: counts loop-filter correction events over WIN_LEN cycles.
// o_ev_final includes the current cycle's event so the last window cycle is evaluated.
module dpll_event_window
    import dpll_gear_ctrl_pkg::*;
#(
    parameter int WIN_LEN = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clear,
    input  logic            i_enable,
    input  logic            i_event,
    output logic [EV_W-1:0] o_ev_count,
    output logic [EV_W-1:0] o_ev_final,
    output logic            o_win_done
);

    localparam int WC_W     = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam int WIN_LAST = WIN_LEN - 1;

    logic [WC_W-1:0] r_win_cnt;
    logic [EV_W-1:0] r_ev;
    logic            w_last;
    logic [EV_W-1:0] w_ev_final;

    assign w_last     = (r_win_cnt == WIN_LAST[WC_W-1:0]);
    assign w_ev_final = ev_sat_inc(r_ev, i_event);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_cnt <= '0;
            r_ev      <= '0;
        end else if (i_clear) begin
            r_win_cnt <= '0;
            r_ev      <= '0;
        end else if (i_enable) begin
            if (w_last) begin
                r_win_cnt <= '0;
                r_ev      <= '0;
            end else begin
                r_win_cnt <= r_win_cnt + 1'b1;
                r_ev      <= w_ev_final;
            end
        end
    end

    assign o_ev_count = r_ev;
    assign o_ev_final = w_ev_final;
    assign o_win_done = i_enable && w_last;

endmodule

// File: rtl/dpll_gear_ctrl.sv
// Gear-shift controller: starts the loop filter at a small K, steps K up after quiet windows,
// flags lock at K_MAX and falls back to K_MIN on a burst of corrections.
module dpll_gear_ctrl
    import dpll_gear_ctrl_pkg::*;
#(
    parameter int WIN_LEN       = 256,
    parameter int SETTLE_LEN    = 64,
    parameter int LOCK_THRESH   = 2,
    parameter int UNLOCK_THRESH = 8,
    parameter int LOCK_WINDOWS  = 4,
    parameter int K_MIN         = 1,
    parameter int K_MAX         = 12
) (
    input  logic             clk,
    input  logic             reset,
    dpll_gear_ctrl_if.slave  io_bus
);

    localparam int K_MIN_C     = (K_MIN < KMODE_LO) ? KMODE_LO : K_MIN;
    localparam int K_MAX_C     = (K_MAX > KMODE_HI) ? KMODE_HI : K_MAX;
    localparam int SW          = (SETTLE_LEN > 2) ? $clog2(SETTLE_LEN) : 1;
    localparam int GW          = $clog2(LOCK_WINDOWS + 1);
    localparam int SETTLE_LAST = SETTLE_LEN - 1;

    localparam logic [K_W-1:0]  KMIN       = K_MIN_C[K_W-1:0];
    localparam logic [K_W-1:0]  KMAX       = K_MAX_C[K_W-1:0];
    localparam logic [EV_W-1:0] LOCK_TH    = LOCK_THRESH[EV_W-1:0];
    localparam logic [EV_W-1:0] UNLOCK_TH  = UNLOCK_THRESH[EV_W-1:0];
    localparam logic [GW:0]     GOOD_TGT   = LOCK_WINDOWS[GW:0];
    localparam logic [SW-1:0]   SET_LAST   = SETTLE_LAST[SW-1:0];

    state_e          r_state, w_state_nxt;
    logic [K_W-1:0]  r_k_mode, w_k_mode_nxt;
    logic            r_k_step, w_k_step_nxt;
    logic            r_locked, w_locked_nxt;
    logic            r_dlf_en;
    logic [GW-1:0]   r_good, w_good_nxt;
    logic [GW:0]     w_good_inc;
    logic [SW-1:0]   r_settle, w_settle_nxt;

    logic            w_event;
    logic            w_win_done;
    logic [EV_W-1:0] w_ev_final;
    logic [EV_W-1:0] w_ev_count;

    assign w_event    = io_bus.carry | io_bus.borrow;
    assign w_good_inc = {1'b0, r_good} + 1'b1;

    // Counters are cleared whenever the next state is not MEASURE, so a
    // discarded or finished window never leaks into the following one.
    dpll_event_window #(
        .WIN_LEN (WIN_LEN)
    ) u_window (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_state_nxt != ST_MEASURE),
        .i_enable   (r_state == ST_MEASURE),
        .i_event    (w_event),
        .o_ev_count (w_ev_count),
        .o_ev_final (w_ev_final),
        .o_win_done (w_win_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_k_mode <= KMIN;
            r_k_step <= 1'b0;
            r_locked <= 1'b0;
            r_dlf_en <= 1'b0;
            r_good   <= '0;
            r_settle <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_k_mode <= w_k_mode_nxt;
            r_k_step <= w_k_step_nxt;
            r_locked <= w_locked_nxt;
            r_dlf_en <= (w_state_nxt != ST_IDLE);
            r_good   <= w_good_nxt;
            r_settle <= w_settle_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_k_mode_nxt = r_k_mode;
        w_k_step_nxt = 1'b0;
        w_locked_nxt = r_locked;
        w_good_nxt   = r_good;
        w_settle_nxt = r_settle;

        case (r_state)
            ST_IDLE: begin
                w_k_mode_nxt = KMIN;
                w_locked_nxt = 1'b0;
                w_good_nxt   = '0;
                w_settle_nxt = '0;
                if (io_bus.start) begin
                    w_state_nxt = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (r_settle == SET_LAST) begin
                    w_settle_nxt = '0;
                    w_state_nxt  = ST_MEASURE;
                end else begin
                    w_settle_nxt = r_settle + 1'b1;
                end
            end

            ST_MEASURE: begin
                if (w_win_done) begin
                    if (w_ev_final > UNLOCK_TH) begin
                        w_k_mode_nxt = KMIN;
                        w_k_step_nxt = (r_k_mode != KMIN);
                        w_good_nxt   = '0;
                        w_locked_nxt = 1'b0;
                        w_settle_nxt = '0;
                        w_state_nxt  = ST_SETTLE;
                    end else if (w_ev_final <= LOCK_TH) begin
                        if (w_good_inc >= GOOD_TGT) begin
                            if (r_k_mode < KMAX) begin
                                w_k_mode_nxt = r_k_mode + 1'b1;
                                w_k_step_nxt = 1'b1;
                                w_good_nxt   = '0;
                                w_settle_nxt = '0;
                                w_state_nxt  = ST_SETTLE;
                            end else begin
                                w_locked_nxt = 1'b1;
                                w_good_nxt   = GOOD_TGT[GW-1:0];
                            end
                        end else begin
                            w_good_nxt = w_good_inc[GW-1:0];
                        end
                    end else begin
                        w_good_nxt = '0;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Stop overrides everything, including a start seen in the same cycle.
        if (io_bus.stop) begin
            w_state_nxt  = ST_IDLE;
            w_k_mode_nxt = KMIN;
            w_k_step_nxt = 1'b0;
            w_locked_nxt = 1'b0;
            w_good_nxt   = '0;
            w_settle_nxt = '0;
        end
    end

    assign io_bus.k_mode     = r_k_mode;
    assign io_bus.dlf_enable = r_dlf_en;
    assign io_bus.k_step     = r_k_step;
    assign io_bus.locked     = r_locked;
    assign io_bus.state_dbg  = r_state;
    assign io_bus.ev_count   = w_ev_count;

    a_k_range: assert property (@(posedge clk) disable iff (reset)
        (r_k_mode >= KMIN) && (r_k_mode <= KMAX));
    a_lock_at_kmax: assert property (@(posedge clk) disable iff (reset)
        r_locked |-> (r_k_mode == KMAX));
    a_step_settles: assert property (@(posedge clk) disable iff (reset)
        r_k_step |-> (r_state == ST_SETTLE));
    a_enable_state: assert property (@(posedge clk) disable iff (reset)
        r_dlf_en == (r_state != ST_IDLE));

endmodule

// File: tb/tb_dpll_gear_ctrl.sv
// Self-checking bench for dpll_gear_ctrl with a small window configuration.
// Window outcomes come from a behavioural K/lock model queued as each window is driven.
module tb_dpll_gear_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    dpll_gear_ctrl_if bus_if ();

    dpll_gear_ctrl #(
        .WIN_LEN       (16),
        .SETTLE_LEN    (4),
        .LOCK_THRESH   (1),
        .UNLOCK_THRESH (4),
        .LOCK_WINDOWS  (2),
        .K_MIN         (1),
        .K_MAX         (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    // Entries: {state[1:0], k_mode[3:0], k_step, locked} one cycle after window end.
    logic [7:0] exp_q[$];

    int   m_k;
    int   m_good;
    logic m_locked;

    task automatic model_reset();
        m_k      = 1;
        m_good   = 0;
        m_locked = 1'b0;
    endtask

    function automatic logic [7:0] model_window(input int ev);
        logic [1:0] st;
        logic       step;
        st   = 2'd2;
        step = 1'b0;
        if (ev > 4) begin
            step     = (m_k != 1);
            m_k      = 1;
            m_good   = 0;
            m_locked = 1'b0;
            st       = 2'd1;
        end else if (ev <= 1) begin
            m_good = m_good + 1;
            if (m_good >= 2) begin
                if (m_k < 3) begin
                    m_k    = m_k + 1;
                    step   = 1'b1;
                    m_good = 0;
                    st     = 2'd1;
                end else begin
                    m_locked = 1'b1;
                    m_good   = 2;
                end
            end
        end else begin
            m_good = 0;
        end
        return {st, 4'(m_k), step, m_locked};
    endfunction

    function automatic logic [7:0] obs();
        return {bus_if.state_dbg, bus_if.k_mode, bus_if.k_step, bus_if.locked};
    endfunction

    function automatic logic [15:0] rand_mask(input int n);
        logic [15:0] m;
        m = '0;
        while ($countones(m) < n) m[$urandom_range(0, 15)] = 1'b1;
        return m;
    endfunction

    task automatic cyc(input logic c, input logic b);
        bus_if.carry  = c;
        bus_if.borrow = b;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic start_loop(input logic c, input string tag);
        logic [6:0] got, exp;
        bus_if.start = 1'b1;
        cyc(c, 1'b0);
        bus_if.start = 1'b0;
        got = {bus_if.state_dbg, bus_if.dlf_enable, bus_if.k_mode};
        exp = {2'd1, 1'b1, 4'd1};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: state/dlf/k got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_settle(input logic inject, input string tag);
        logic [10:0] got, exp;
        for (int i = 0; i < 4; i++) begin
            cyc(inject, 1'b0);
            exp = {(i == 3) ? 2'd2 : 2'd1, 8'd0, 1'b0};
            got = {bus_if.state_dbg, bus_if.ev_count, bus_if.k_step};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s_settle%0d: state/ev/step got %h expected %h", tag, i, got, exp);
            end
        end
    endtask

    task automatic run_window(input logic [15:0] cm, input logic [15:0] bm, input string tag);
        logic [15:0] em;
        logic [3:0]  k_before;
        logic [13:0] mid_got, mid_exp;
        logic [7:0]  got, exp;
        em       = cm | bm;
        k_before = 4'(m_k);
        exp_q.push_back(model_window($countones(em)));
        for (int i = 0; i < 16; i++) begin
            cyc(cm[i], bm[i]);
            if (i == 14) begin
                mid_exp = {2'd2, k_before, 8'($countones(em & 16'h7fff))};
                mid_got = {bus_if.state_dbg, bus_if.k_mode, bus_if.ev_count};
                checks++;
                if (mid_got !== mid_exp) begin
                    failures++;
                    $display("FAIL %s_mid: state/k/ev got %h expected %h", tag, mid_got, mid_exp);
                end
            end
        end
        got = obs();
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s_end: state/k/step/locked got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic test_reset();
        logic [8:0] got;
        reset = 1'b1;
        #1;
        got = {bus_if.state_dbg, bus_if.k_mode, bus_if.dlf_enable, bus_if.locked, bus_if.k_step};
        checks++;
        if (got !== 9'b00_0001_000) begin
            failures++;
            $display("FAIL reset_async: got %h expected %h", got, 9'b00_0001_000);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0);
            got = {bus_if.state_dbg, bus_if.k_mode, bus_if.dlf_enable, bus_if.locked, bus_if.k_step};
            checks++;
            if (got !== 9'b00_0001_000 || bus_if.ev_count !== 8'd0) begin
                failures++;
                $display("FAIL idle_hold%0d: got %h ev %0d expected %h ev 0", i, got, bus_if.ev_count,
                         9'b00_0001_000);
            end
        end
        model_reset();
    endtask

    task automatic test_acquire();
        int base;
        base = cyc_n;
        start_loop(1'b0, "acq_start");
        run_settle(1'b0, "acq1");
        run_window(16'h0, 16'h0, "acq_k1_w1");
        run_window(16'h0, 16'h0, "acq_k1_w2");
        checks++;
        if ((cyc_n - base) != 37 || bus_if.k_mode !== 4'd2) begin
            failures++;
            $display("FAIL acq_step1_time: cycle %0d k %0d expected cycle 37 k 2", cyc_n - base, bus_if.k_mode);
        end
        run_settle(1'b0, "acq2");
        run_window(16'h0, 16'h0, "acq_k2_w1");
        run_window(16'h0, 16'h0, "acq_k2_w2");
        run_settle(1'b0, "acq3");
        run_window(16'h0, 16'h0, "acq_k3_w1");
        run_window(16'h0, 16'h0, "acq_lock");
        checks++;
        if ((cyc_n - base) != 109 || bus_if.locked !== 1'b1) begin
            failures++;
            $display("FAIL acq_lock_time: cycle %0d locked %b expected cycle 109 locked 1", cyc_n - base,
                     bus_if.locked);
        end
        run_window(rand_mask(1), 16'h0, "locked_hold");
    endtask

    task automatic test_unlock();
        run_window(rand_mask(5), 16'h0, "unlock");
        run_settle(1'b0, "unlock");
    endtask

    task automatic test_boundaries();
        run_window(16'h0, rand_mask(6), "unlock_at_kmin");
        run_settle(1'b0, "kmin");
        run_window(16'h8000, 16'h0, "one_ev_last");
        run_window(rand_mask(2), 16'h0, "two_ev");
        run_window(16'h0, 16'h0001, "one_ev_first");
        run_window(16'h0, rand_mask(4), "four_ev");
        run_window(16'h0008, 16'h0008, "carry_borrow_same");
        run_window(16'h0020, 16'h0, "quiet_step");
    endtask

    task automatic test_stop();
        logic [15:0] got;
        int          ev;
        logic        c;
        run_settle(1'b0, "pre_stop");
        ev = 0;
        for (int i = 0; i < 7; i++) begin
            c = 1'($urandom_range(0, 1));
            ev += int'(c);
            cyc(c, 1'b0);
        end
        checks++;
        if (bus_if.ev_count !== 8'(ev) || bus_if.k_mode !== 4'd2) begin
            failures++;
            $display("FAIL pre_stop_ev: ev %0d k %0d expected ev %0d k 2", bus_if.ev_count, bus_if.k_mode, ev);
        end
        bus_if.stop = 1'b1;
        cyc(1'b1, 1'b0);
        bus_if.stop = 1'b0;
        got = {bus_if.state_dbg, bus_if.k_mode, bus_if.dlf_enable, bus_if.locked, bus_if.k_step,
               bus_if.ev_count[6:0]};
        checks++;
        if (got !== 16'h0400 || bus_if.ev_count[7] !== 1'b0) begin
            failures++;
            $display("FAIL stop_idle: got %h expected %h", got, 16'h0400);
        end
        model_reset();
        bus_if.start = 1'b1;
        bus_if.stop  = 1'b1;
        cyc(1'b0, 1'b0);
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        checks++;
        if (bus_if.state_dbg !== 2'd0 || bus_if.dlf_enable !== 1'b0) begin
            failures++;
            $display("FAIL stop_over_start: state %0d dlf %b expected state 0 dlf 0", bus_if.state_dbg,
                     bus_if.dlf_enable);
        end
    endtask

    task automatic test_reset_mid_settle();
        logic [8:0] got;
        start_loop(1'b0, "rst_start");
        run_settle(1'b0, "rst1");
        run_window(16'h0, 16'h0, "rst_w1");
        run_window(16'h0, 16'h0, "rst_w2");
        cyc(1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        got = {bus_if.state_dbg, bus_if.k_mode, bus_if.dlf_enable, bus_if.locked, bus_if.k_step};
        checks++;
        if (got !== 9'b00_0001_000) begin
            failures++;
            $display("FAIL reset_mid_settle: got %h expected %h", got, 9'b00_0001_000);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        cyc(1'b0, 1'b0);
        checks++;
        if (bus_if.state_dbg !== 2'd0 || bus_if.k_mode !== 4'd1) begin
            failures++;
            $display("FAIL post_reset_idle: state %0d k %0d expected state 0 k 1", bus_if.state_dbg,
                     bus_if.k_mode);
        end
    endtask

    task automatic test_settle_mask();
        start_loop(1'b1, "mask_start");
        run_settle(1'b1, "mask1");
        run_window(16'h0, 16'h0, "mask_w1");
        run_window(16'h0, 16'h0, "mask_w2");
        run_settle(1'b1, "mask2");
        run_window(16'h0, 16'h0, "mask_w3");
    endtask

    initial begin
        bus_if.start  = 1'b0;
        bus_if.stop   = 1'b0;
        bus_if.carry  = 1'b0;
        bus_if.borrow = 1'b0;
        model_reset();

        test_reset();
        test_acquire();
        test_unlock();
        test_boundaries();
        test_stop();
        test_reset_mid_settle();
        test_settle_mask();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
